// File: rtl/stim_pkg.sv
// Shared definitions for the stim_gen vector generator: FSM state type and LFSR constants.
// The LFSR items are only used when STIM_LFSR_EN is defined.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int LFSR_W = 16;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: mask bit k taps x^(16-k).
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 16-bit Fibonacci LFSR for the random mode of stim_gen (instantiated only with STIM_LFSR_EN).
// load takes priority over step; a zero seed would lock the LFSR, so it is swapped for the default.
module stim_lfsr
    import stim_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            q_reg <= lfsr_next(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/stim_gen.sv
// Stimulus generator for an N-bit ALU: exhaustive {S,Cin,B,A} sweep with pause/hold and done.
// Optional random mode (LFSR vectors, NUM_VEC of them) is enabled by defining STIM_LFSR_EN.
module stim_gen
    import stim_pkg::*;
#(
    parameter int N       = 4,
    parameter int NUM_VEC = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             pause,
`ifdef STIM_LFSR_EN
    input  logic             mode,
    input  logic [15:0]      seed,
`endif
    output logic [N-1:0]     A,
    output logic [N-1:0]     B,
    output logic [1:0]       S,
    output logic             Cin,
    output logic             vec_valid,
    output logic [2*N+2:0]   vec_index,
    output logic             busy,
    output logic             done
);

    localparam int IW = 2*N+3;
    localparam logic [IW-1:0] EXH_LAST  = {IW{1'b1}};
    localparam logic [IW-1:0] RAND_LAST = IW'(NUM_VEC - 1);

    state_t        state_reg;
    logic [IW-1:0] index_reg;
    logic          valid_reg;
    logic          busy_reg;
    logic          done_reg;

    logic          rand_mode;
    logic [IW-1:0] operand_bits;
    logic          last_vec;
    logic          start_run;
    logic          advance;

    assign last_vec  = (index_reg == (rand_mode ? RAND_LAST : EXH_LAST));
    assign start_run = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    // The last vector goes to DONE even when pause is high, so HOLD never sees last_vec.
    assign advance   = ((state_reg == ST_RUN) && !pause && !last_vec) ||
                       ((state_reg == ST_HOLD) && !pause);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg <= ST_RUN;
                        index_reg <= '0;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_vec) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (pause) begin
                        state_reg <= ST_HOLD;
                    end else begin
                        index_reg <= index_reg + IW'(1);
                        valid_reg <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_reg <= ST_RUN;
                        index_reg <= index_reg + IW'(1);
                        valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STIM_LFSR_EN
    logic        mode_reg;
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_reg <= 1'b0;
        end else if (start_run) begin
            mode_reg <= mode;
        end
    end

    stim_lfsr u_lfsr (
        .CLK  (CLK),
        .RST  (RST),
        .load (start_run),
        .seed (seed),
        .step (advance),
        .q    (lfsr_q)
    );

    assign rand_mode    = mode_reg;
    assign operand_bits = mode_reg ? lfsr_q[IW-1:0] : index_reg;
    assign lfsr_unused  = ^lfsr_q;
`else
    logic unused_ctrl;

    assign rand_mode    = 1'b0;
    assign operand_bits = index_reg;
    assign unused_ctrl  = start_run ^ advance;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_operands
            assign A[gi] = operand_bits[gi];
            assign B[gi] = operand_bits[N + gi];
        end
    endgenerate

    assign Cin       = operand_bits[2*N];
    assign S         = operand_bits[2*N+2:2*N+1];
    assign vec_valid = valid_reg;
    assign vec_index = index_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_stim_gen.sv
// Self-checking bench for stim_gen: full sweeps, pause/hold, start ignored while busy, async reset,
// restart from DONE and (with STIM_LFSR_EN) random-mode runs against an arithmetic reference.
module tb_stim_gen;

    localparam int N       = 4;
    localparam int NUM_VEC = 1000;
    localparam int IW      = 2*N+3;
    localparam int NTBL    = 9;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          pause;
`ifdef STIM_LFSR_EN
    logic          mode;
    logic [15:0]   seed;
`endif
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [1:0]    S;
    logic          Cin;
    logic          vec_valid;
    logic [IW-1:0] vec_index;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int a;
        int b;
        int cin;
        int s;
    } tvec_t;

    tvec_t tbl [NTBL];

    stim_gen #(.N(N), .NUM_VEC(NUM_VEC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .pause     (pause),
`ifdef STIM_LFSR_EN
        .mode      (mode),
        .seed      (seed),
`endif
        .A         (A),
        .B         (B),
        .S         (S),
        .Cin       (Cin),
        .vec_valid (vec_valid),
        .vec_index (vec_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference polynomial x^16+x^14+x^13+x^11+1, shifting right, new bit enters at the MSB.
    function automatic logic [15:0] tb_lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    // Operand word is {S,Cin,B,A} with A in the LSBs; split it by plain arithmetic.
    task automatic check_vec(input int k, input logic [15:0] lst, input bit rmode, input bit exp_valid);
        int w;
        w = rmode ? int'(lst & 16'h07FF) : k;
        check("vec_valid", int'(vec_valid), int'(exp_valid));
        check("vec_index", int'(vec_index), k);
        check("A", int'(A), w % (1 << N));
        check("B", int'(B), (w / (1 << N)) % (1 << N));
        check("Cin", int'(Cin), (w / (1 << (2*N))) % 2);
        check("S", int'(S), (w / (1 << (2*N+1))) % 4);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, int'(vec_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_index"}, int'(vec_index), 0);
    endtask

    // One complete run from IDLE/DONE to DONE; next vector appears iff pause was low at the edge.
    task automatic run_one(input bit events, input bit rnd, input bit rmode,
                           input logic [15:0] seed_in, input bit use_tbl);
        int k;
        int last;
        int pause_left;
        int ti;
        int holds;
        bit used100;
        bit p;
        logic [15:0] lst;

        last       = rmode ? NUM_VEC - 1 : (1 << IW) - 1;
        lst        = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
        pause_left = 0;
        used100    = 1'b0;
        ti         = 0;
        holds      = 0;
`ifdef STIM_LFSR_EN
        mode = rmode;
        seed = seed_in;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef STIM_LFSR_EN
        seed = 16'($urandom);
        mode = 1'($urandom);
`endif
        k = 0;
        check_vec(k, lst, rmode, 1'b1);
        check("busy_first", int'(busy), 1);
        if (use_tbl && k == tbl[ti].idx) ti++;

        while (k < last) begin
            if (events && k == 100 && !used100) begin
                pause_left = 3;
                used100    = 1'b1;
            end
            if (pause_left > 0) begin
                p = 1'b1;
                pause_left--;
            end else begin
                p = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            pause = p;
            start = (events && k == 10) ? 1'b1 : 1'b0;
            tick();
            start = 1'b0;
            if (!p) begin
                k++;
                if (rmode) lst = tb_lfsr_step(lst);
            end else begin
                holds++;
            end
            check_vec(k, lst, rmode, !p);
            check("busy_run", int'(busy), 1);
            check("done_run", int'(done), 0);
            if (use_tbl && !p && ti < NTBL && k == tbl[ti].idx) begin
                check("tbl_A", int'(A), tbl[ti].a);
                check("tbl_B", int'(B), tbl[ti].b);
                check("tbl_Cin", int'(Cin), tbl[ti].cin);
                check("tbl_S", int'(S), tbl[ti].s);
                ti++;
            end
        end

        // DONE wins even if pause is high on the last vector's cycle.
        p = rnd ? 1'($urandom) : 1'b1;
        pause = p;
        tick();
        pause = 1'b0;
        check_vec(k, lst, rmode, 1'b0);
        check("done_end", int'(done), 1);
        check("busy_end", int'(busy), 0);
        tick();
        check("done_stays", int'(done), 1);
        check("index_stays", int'(vec_index), last);
        if (use_tbl) check("tbl_visited", ti, NTBL);
        $display("run complete: mode=%0d vectors=%0d holds=%0d errors=%0d", rmode, k + 1, holds, errors);
    endtask

    initial begin
        tbl[0] = '{idx: 0,    a: 0,  b: 0,  cin: 0, s: 0};
        tbl[1] = '{idx: 1,    a: 1,  b: 0,  cin: 0, s: 0};
        tbl[2] = '{idx: 16,   a: 0,  b: 1,  cin: 0, s: 0};
        tbl[3] = '{idx: 255,  a: 15, b: 15, cin: 0, s: 0};
        tbl[4] = '{idx: 256,  a: 0,  b: 0,  cin: 1, s: 0};
        tbl[5] = '{idx: 511,  a: 15, b: 15, cin: 1, s: 0};
        tbl[6] = '{idx: 512,  a: 0,  b: 0,  cin: 0, s: 1};
        tbl[7] = '{idx: 1234, a: 2,  b: 13, cin: 0, s: 2};
        tbl[8] = '{idx: 2047, a: 15, b: 15, cin: 1, s: 3};

        RST   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
`ifdef STIM_LFSR_EN
        mode  = 1'b0;
        seed  = 16'h0;
`endif
        @(negedge CLK);
        check_vec(0, 16'h0, 1'b0, 1'b0);
        check_idle("reset");
        tick();
        RST = 1'b0;
        repeat (3) tick();
        check_idle("post_reset");
        $display("reset: errors=%0d", errors);

        // Sweep with start at index 10 and a 3-cycle pause at index 100, plus table spot checks.
        run_one(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        // Restart from DONE with random pauses; the model expects the identical sequence.
        run_one(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

        // Asynchronous reset mid-run.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        check("idx_500", int'(vec_index), 500);
        #2 RST = 1'b1;
        #1;
        check_vec(0, 16'h0, 1'b0, 1'b0);
        check_idle("async_reset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) tick();
        check_idle("no_resume");
        $display("mid-run reset: errors=%0d", errors);
        run_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

`ifdef STIM_LFSR_EN
        run_one(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        run_one(1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
        run_one(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
